// File: rtl/usb_tx_pkt_arb.sv
// usb_tx_pkt_arb: packet-atomic round-robin arbiter merging NUM_CH byte
// streams onto one registered tx stream, truncating packets over MAX_PKT.
// Ports: USB_CLK/USB_RSTn (sync, active-low); in_valid/in_ready/in_byte/
// in_last per channel; tx_valid/tx_ready/tx_byte/tx_last/tx_ch merged out;
// busy (not idle); ovl_err (truncation pulse); pkt_cnt (per-channel count).
// Macro USB_ARB_PKT_CNT_EN enables the packet counters; otherwise pkt_cnt=0.
module usb_tx_pkt_arb #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int MAX_PKT = 64,
    parameter int CNT_W   = 16,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                      USB_CLK,
    input  logic                      USB_RSTn,
    input  logic [NUM_CH-1:0]         in_valid,
    output logic [NUM_CH-1:0]         in_ready,
    input  logic [NUM_CH*DATA_W-1:0]  in_byte,
    input  logic [NUM_CH-1:0]         in_last,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [DATA_W-1:0]         tx_byte,
    output logic                      tx_last,
    output logic [CH_W-1:0]           tx_ch,
    output logic                      busy,
    output logic                      ovl_err,
    output logic [NUM_CH*CNT_W-1:0]   pkt_cnt
);

    localparam int BC_W = $clog2(MAX_PKT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        DROP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   rr_sel;
    logic [CH_W-1:0]   rr_idx;
    logic [BC_W-1:0]   byte_cnt;
    logic              out_free;
    logic              g_last;
    logic              at_max;
    logic              lock_acc;
    logic              drop_acc;
    logic [DATA_W-1:0] ch_byte [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_split
        assign ch_byte[g] = in_byte[g*DATA_W +: DATA_W];
    end

    assign out_free = !tx_valid || tx_ready;
    assign g_last   = in_last[grant];
    assign at_max   = byte_cnt == BC_W'(MAX_PKT - 1);
    assign lock_acc = (state == LOCK) && in_valid[grant] && out_free;
    assign drop_acc = (state == DROP) && in_valid[grant];
    assign busy     = state != IDLE;

    // Search from rr_ptr+1 upward; walking down lets the nearest win.
    always_comb begin
        rr_sel = rr_ptr;
        rr_idx = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            rr_idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (in_valid[rr_idx]) rr_sel = rr_idx;
        end
    end

    always_ff @(posedge USB_CLK) begin
        if (!USB_RSTn) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = '0;
        unique case (state)
            IDLE: begin
                if (|in_valid) state_nxt = LOCK;
            end
            LOCK: begin
                in_ready[grant] = out_free;
                if (lock_acc) begin
                    if (g_last)      state_nxt = IDLE;
                    else if (at_max) state_nxt = DROP;
                end
            end
            DROP: begin
                // Sink the overlength tail without waiting on tx.
                in_ready[grant] = 1'b1;
                if (drop_acc && g_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge USB_CLK) begin
        if (!USB_RSTn) begin
            grant    <= '0;
            rr_ptr   <= CH_W'(NUM_CH - 1);
            byte_cnt <= '0;
            tx_valid <= 1'b0;
            tx_byte  <= '0;
            tx_last  <= 1'b0;
            tx_ch    <= '0;
            ovl_err  <= 1'b0;
        end else begin
            ovl_err <= 1'b0;
            if (tx_ready) tx_valid <= 1'b0;
            if (state == IDLE && |in_valid) grant <= rr_sel;
            if (lock_acc) begin
                tx_valid <= 1'b1;
                tx_byte  <= ch_byte[grant];
                tx_ch    <= grant;
                tx_last  <= g_last || at_max;
                if (g_last) begin
                    byte_cnt <= '0;
                    rr_ptr   <= grant;
                end else if (at_max) begin
                    byte_cnt <= '0;
                    ovl_err  <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
            if (drop_acc && g_last) rr_ptr <= grant;
        end
    end

`ifdef USB_ARB_PKT_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic             pkt_end;

    // A truncated packet counts once, when its tail is sunk in DROP.
    assign pkt_end = (lock_acc || drop_acc) && g_last;

    always_ff @(posedge USB_CLK) begin
        if (!USB_RSTn) begin
            for (int g = 0; g < NUM_CH; g++) cnt_q[g] <= '0;
        end else if (pkt_end) begin
            cnt_q[grant] <= cnt_q[grant] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign pkt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_usb_tx_pkt_arb.sv
// tb_usb_tx_pkt_arb: self-checking bench for usb_tx_pkt_arb.
// Packet table plus hand-written sequences; tx beats checked from a queue.
module tb_usb_tx_pkt_arb;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 8;
    localparam int MAX_PKT = 64;
    localparam int CNT_W   = 16;

    logic                     USB_CLK = 1'b0;
    logic                     USB_RSTn;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*DATA_W-1:0] in_byte;
    logic [NUM_CH-1:0]        in_last;
    logic                     tx_valid;
    logic                     tx_ready;
    logic [DATA_W-1:0]        tx_byte;
    logic                     tx_last;
    logic [1:0]               tx_ch;
    logic                     busy;
    logic                     ovl_err;
    logic [NUM_CH*CNT_W-1:0]  pkt_cnt;

    usb_tx_pkt_arb #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .MAX_PKT(MAX_PKT),
        .CNT_W  (CNT_W)
    ) dut (
        .USB_CLK (USB_CLK),
        .USB_RSTn(USB_RSTn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_byte (in_byte),
        .in_last (in_last),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_byte (tx_byte),
        .tx_last (tx_last),
        .tx_ch   (tx_ch),
        .busy    (busy),
        .ovl_err (ovl_err),
        .pkt_cnt (pkt_cnt)
    );

    always #5 USB_CLK = ~USB_CLK;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] b;
        logic       last;
    } beat_t;

    typedef struct {
        int         grp;
        int         ch;
        int         len;
        logic [7:0] base;
        int         ovl;
    } vec_t;

    vec_t       tbl[$];
    beat_t      exp_q[$];
    logic [8:0] src_q [NUM_CH][$];
    int         cnt_model [NUM_CH];
    int         checks;
    int         errors;
    int         ovl_seen;
    int         cyc;
    int         first_fire;
    int         last_fire;
    int         rdy_mode;
    bit         force_valid;
    bit         st_prev;
    logic [7:0] st_byte;
    logic       st_last;
    logic [1:0] st_ch;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive();
        for (int g = 0; g < NUM_CH; g++) begin
            if (force_valid) begin
                in_valid[g] = 1'b1;
                in_last[g]  = 1'b0;
                in_byte[g*DATA_W +: DATA_W] = 8'hFF;
            end else if (src_q[g].size() > 0) begin
                in_valid[g] = 1'b1;
                in_last[g]  = src_q[g][0][8];
                in_byte[g*DATA_W +: DATA_W] = src_q[g][0][7:0];
            end else begin
                in_valid[g] = 1'b0;
                in_last[g]  = 1'b0;
                in_byte[g*DATA_W +: DATA_W] = '0;
            end
        end
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = cyc[0];
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic step();
        logic [NUM_CH-1:0] hs;
        beat_t             e;
        @(negedge USB_CLK);
        hs = USB_RSTn ? (in_valid & in_ready) : '0;
        if (st_prev) begin
            check("hold_valid", 32'(tx_valid), 32'd1);
            check("hold_byte", 32'(tx_byte), 32'(st_byte));
            check("hold_last", 32'(tx_last), 32'(st_last));
            check("hold_ch", 32'(tx_ch), 32'(st_ch));
        end
        st_prev = (tx_valid === 1'b1) && (tx_ready === 1'b0);
        st_byte = tx_byte;
        st_last = tx_last;
        st_ch   = tx_ch;
        if (ovl_err === 1'b1) ovl_seen++;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx: got ch%0d byte %0h last %0b, required none",
                         tx_ch, tx_byte, tx_last);
            end else begin
                e = exp_q.pop_front();
                check("tx_byte", 32'(tx_byte), 32'(e.b));
                check("tx_last", 32'(tx_last), 32'(e.last));
                check("tx_ch", 32'(tx_ch), 32'(e.ch));
            end
        end
        @(posedge USB_CLK);
        #1;
        cyc++;
        for (int g = 0; g < NUM_CH; g++)
            if (hs[g] === 1'b1 && src_q[g].size() > 0) void'(src_q[g].pop_front());
        drive();
    endtask

    function automatic bit src_empty();
        for (int g = 0; g < NUM_CH; g++)
            if (src_q[g].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_byte(int ch, logic [7:0] b, logic last);
        src_q[ch].push_back({last, b});
        exp_q.push_back('{ch: 2'(ch), b: b, last: last});
        if (last) cnt_model[ch]++;
    endtask

    task automatic send(int ch, int len, logic [7:0] base);
        int         n;
        logic [7:0] b;
        n = (len > MAX_PKT) ? MAX_PKT : len;
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i);
            src_q[ch].push_back({(i == len - 1), b});
            if (i < n) exp_q.push_back('{ch: 2'(ch), b: b, last: (i == n - 1)});
        end
        cnt_model[ch]++;
    endtask

    task automatic wait_idle(string name, int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && src_empty() && busy === 1'b0 && tx_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: %0d beats pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic run_group(int k, string name);
        int ob;
        int eo;
        ob = ovl_seen;
        eo = 0;
        foreach (tbl[i]) begin
            if (tbl[i].grp == k) begin
                send(tbl[i].ch, tbl[i].len, tbl[i].base);
                eo += tbl[i].ovl;
            end
        end
        drive();
        wait_idle(name, 3000);
        check({name, "_ovl"}, 32'(ovl_seen - ob), 32'(eo));
    endtask

    task automatic check_cnt(string name);
        for (int g = 0; g < NUM_CH; g++) begin
`ifdef USB_ARB_PKT_CNT_EN
            check(name, 32'(pkt_cnt[g*CNT_W +: CNT_W]), 32'(cnt_model[g] % (1 << CNT_W)));
`else
            check(name, 32'(pkt_cnt[g*CNT_W +: CNT_W]), 32'd0);
`endif
        end
    endtask

    task automatic check_rst(string name);
        check({name, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({name, "_tx_byte"}, 32'(tx_byte), 32'd0);
        check({name, "_tx_last"}, 32'(tx_last), 32'd0);
        check({name, "_tx_ch"}, 32'(tx_ch), 32'd0);
        check({name, "_in_ready"}, 32'(in_ready), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_ovl_err"}, 32'(ovl_err), 32'd0);
        check({name, "_pkt_cnt"}, 32'(pkt_cnt != '0), 32'd0);
    endtask

    initial begin
        // grp 2: fairness, 4: overlength, 5: exact max, 6: ch0 counter run
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NUM_CH; c++)
                tbl.push_back('{2, c, 3, 8'(16 * c + 4 * r), 0});
        tbl.push_back('{4, 2, 70, 8'h40, 1});
        tbl.push_back('{4, 3, 3, 8'h90, 0});
        tbl.push_back('{5, 1, 64, 8'h00, 0});
        tbl.push_back('{6, 0, 2, 8'h20, 0});
        tbl.push_back('{6, 0, 66, 8'h30, 1});
        tbl.push_back('{6, 0, 1, 8'h80, 0});
        tbl.push_back('{6, 0, 5, 8'h88, 0});
        tbl.push_back('{6, 0, 64, 8'hC0, 0});

        checks      = 0;
        errors      = 0;
        ovl_seen    = 0;
        cyc         = 0;
        first_fire  = -1;
        last_fire   = -1;
        rdy_mode    = 0;
        st_prev     = 1'b0;
        force_valid = 1'b1;
        USB_RSTn    = 1'b0;
        for (int g = 0; g < NUM_CH; g++) cnt_model[g] = 0;
        drive();

        step();
        step();
        check_rst("reset");

        USB_RSTn    = 1'b1;
        force_valid = 1'b0;
        drive();

        first_fire = -1;
        run_group(2, "fair");
        check("fair_span", 32'(last_fire - first_fire), 32'd30);

        send(0, 1, 8'h33);
        drive();
        wait_idle("single", 100);

        rdy_mode = 1;
        push_byte(1, 8'hA5, 1'b0);
        push_byte(1, 8'h5A, 1'b0);
        push_byte(1, 8'hC3, 1'b1);
        send(0, 3, 8'h10);
        drive();
        wait_idle("backpressure", 200);

        rdy_mode = 0;
        run_group(4, "overlen");
        rdy_mode = 2;
        run_group(5, "maxlen");
        rdy_mode = 0;
        run_group(6, "cnt");
        check_cnt("pkt_cnt");

        send(1, 20, 8'h60);
        drive();
        repeat (6) step();
        check("mid_busy", 32'(busy), 32'd1);
        USB_RSTn = 1'b0;
        step();
        step();
        for (int g = 0; g < NUM_CH; g++) begin
            src_q[g].delete();
            cnt_model[g] = 0;
        end
        exp_q.delete();
        drive();
        check_rst("mid_reset");
        USB_RSTn = 1'b1;
        drive();

        send(0, 2, 8'hB0);
        send(3, 2, 8'hA0);
        drive();
        wait_idle("post_reset", 100);
        check_cnt("post_cnt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
